apb_axi_bridge: RTL and testbench
=================================

APB_AXI_BRIDGE -- requirements
Module: apb_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width on both sides.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, AXI response timeout in cycles (used only when the timeout feature is compiled in).
REQ-003 ACLK  input  1  clock; all logic rising-edge.
REQ-004 ARESETn  input  1  reset, asynchronous, active-low.
REQ-005 PSEL  input  1  APB slave select.
REQ-006 PENABLE  input  1  APB access phase.
REQ-007 PWRITE  input  1  1 = write, 0 = read.
REQ-008 PADDR  input  ADDR_W  APB address.
REQ-009 PWDATA  input  32  APB write data.
REQ-010 PRDATA  output  32  APB read data.
REQ-011 PREADY  output  1  APB transfer complete.
REQ-012 PSLVERR  output  1  APB error.
REQ-013 AWADDR  output  ADDR_W  AXI-Lite write address.
REQ-014 AWVALID  output  1  write address valid.
REQ-015 AWREADY  input  1  write address accepted.
REQ-016 WDATA  output  32  write data.
REQ-017 WSTRB  output  4  write strobes, constant 4'hF.
REQ-018 WVALID  output  1  write data valid.
REQ-019 WREADY  input  1  write data accepted.
REQ-020 BRESP  input  2  write response.
REQ-021 BVALID  input  1  write response valid.
REQ-022 BREADY  output  1  write response accept.
REQ-023 ARADDR  output  ADDR_W  read address.
REQ-024 ARVALID  output  1  read address valid.
REQ-025 ARREADY  input  1  read address accepted.
REQ-026 RDATA  input  32  read data.
REQ-027 RRESP  input  2  read response.
REQ-028 RVALID  input  1  read data valid.
REQ-029 RREADY  output  1  read data accept.

Function
REQ-030 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; all outputs registered.
REQ-031 IDLE: on PSEL=1, PENABLE=0, latch PADDR/PWDATA into AWADDR/ARADDR/WDATA; go to WR_REQ with AWVALID=WVALID=1 if PWRITE=1, else RD_REQ with ARVALID=1.
REQ-032 WR_REQ: AWVALID drops the cycle after AWREADY=1, WVALID the cycle after WREADY=1, independently; same-cycle or either-order acceptance is legal; both accepted -> WR_RESP with BREADY=1.
REQ-033 RD_REQ: ARVALID drops after ARREADY=1 -> RD_RESP with RREADY=1.
REQ-034 WR_RESP/RD_RESP: on BVALID/RVALID, drop BREADY/RREADY, register PSLVERR=RESP[1] and PRDATA=RDATA (read) or 0 (write), then go to DONE.
REQ-035 DONE: PREADY=1 for exactly one cycle, then IDLE; PREADY=0 in every other state.
REQ-036 VALID signals SHALL NOT drop before their READY handshake; address/data SHALL stay stable while VALID is high.
REQ-037 Minimum latency: setup edge T0, xVALID high at T1, PREADY high at T3 when the slave responds with zero wait cycles.
REQ-038 PSEL/PENABLE dropping mid-transfer (APB violation) SHALL be ignored; the AXI transaction completes and DONE still pulses once.
REQ-039 Only one outstanding transaction; new APB setups are ignored outside IDLE.

Reset
REQ-040 On ARESETn=0, any state -> IDLE; PREADY, PSLVERR, all xVALID/xREADY outputs = 0; PRDATA, AWADDR, ARADDR, WDATA = 0; an in-flight AXI transaction is abandoned.

Configuration
REQ-041 Macro APB_AXI_BRIDGE_TIMEOUT_EN: when defined, a counter runs in WR_REQ/WR_RESP/RD_REQ/RD_RESP; when it reaches TIMEOUT_CYC it forces DONE with PSLVERR=1 and PRDATA=32'hDEAD_BEEF and deasserts all AXI VALID/READY outputs; when undefined there is no counter and the bridge waits indefinitely.

Structure
REQ-042 The state enum and the OKAY/SLVERR response constants SHALL live in package apb_axi_pkg; the timeout counter SHALL be sub-module bridge_timeout_cnt; no other sub-modules.

Verification
REQ-043 APB write 0x1000 = 0xA5A5_0001, AWREADY/WREADY in the same cycle, BRESP=00 -> one AW/W beat with WSTRB=F, PREADY at T3, PSLVERR=0.
REQ-044 Write with WREADY 2 cycles before AWREADY -> WVALID drops first, AWVALID holds, exactly one B handshake, PREADY once.
REQ-045 APB read 0x2004, ARREADY delayed 3 cycles, RDATA=0x1234_5678, RRESP=10 -> PRDATA=0x1234_5678, PSLVERR=1.
REQ-046 ARESETn asserted in WR_RESP -> all outputs 0 the same cycle, IDLE; a following read completes normally.
REQ-047 With APB_AXI_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=8, BVALID never asserted -> PREADY with PSLVERR=1 after the count; without the macro, PREADY stays 0.

Source files
------------

// File: rtl/apb_axi_pkg.sv
// Shared types and AXI response constants for the APB to AXI-Lite bridge.
package apb_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp & RESP_SLVERR) != RESP_OKAY;
  endfunction

endpackage

// File: rtl/bridge_timeout_cnt.sv
// AXI response watchdog for the bridge; only present when APB_AXI_BRIDGE_TIMEOUT_EN is defined.
`ifdef APB_AXI_BRIDGE_TIMEOUT_EN
module bridge_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic en_i,
  output logic expire_o
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts busy cycles and restarts from zero whenever the bridge is not busy.
  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CNT_MAX);

endmodule
`endif

// File: rtl/apb_axi_bridge.sv
// APB slave to AXI-Lite master bridge, one transaction at a time, all outputs registered.
// Optional response timeout enabled by defining APB_AXI_BRIDGE_TIMEOUT_EN.
module apb_axi_bridge
  import apb_axi_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic [3:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]       wdata_q, wdata_d, prdata_q, prdata_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              pready_q, pready_d, pslverr_q, pslverr_d;
  logic              aw_pend, w_pend, timeout;

`ifdef APB_AXI_BRIDGE_TIMEOUT_EN
  logic busy;
  assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                (state_q == RD_REQ) || (state_q == RD_RESP);

  bridge_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .en_i     (busy),
    .expire_o (timeout)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign timeout        = 1'b0;
`endif

  // A channel is still pending while its VALID is up and READY has not been seen.
  assign aw_pend = awvalid_q && !AWREADY;
  assign w_pend  = wvalid_q && !WREADY;

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;

    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          awaddr_d  = PADDR;
          araddr_d  = PADDR;
          wdata_d   = PWDATA;
          pslverr_d = 1'b0;
          if (PWRITE) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (BVALID) begin
          state_d   = DONE;
          bready_d  = 1'b0;
          pslverr_d = resp_is_err(BRESP);
          prdata_d  = '0;
          pready_d  = 1'b1;
        end
      end
      RD_REQ: begin
        if (ARREADY) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (RVALID) begin
          state_d   = DONE;
          rready_d  = 1'b0;
          pslverr_d = resp_is_err(RRESP);
          prdata_d  = RDATA;
          pready_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog expiry abandons the AXI side and completes the APB side with an error.
    if (timeout) begin
      state_d   = DONE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      pready_d  = 1'b1;
      pslverr_d = 1'b1;
      prdata_d  = TIMEOUT_RDATA;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign AWADDR  = awaddr_q;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = 4'hF;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign ARADDR  = araddr_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

endmodule

// File: tb/tb_apb_axi_bridge.sv
// Directed bench for apb_axi_bridge: writes, reads, handshake ordering, reset and timeout.
module tb_apb_axi_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [3:0]  WSTRB;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, pr_cnt = 0;

  apb_axi_bridge #(
    .ADDR_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Handshake and PREADY tallies, sampled mid-cycle where the next rising edge will see them.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      aw_hs  <= aw_hs  + int'(AWVALID && AWREADY);
      w_hs   <= w_hs   + int'(WVALID && WREADY);
      b_hs   <= b_hs   + int'(BVALID && BREADY);
      pr_cnt <= pr_cnt + int'(PREADY);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Presents an APB setup phase, lets edge T0 capture it, then enters the access phase.
  task automatic apb_setup(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = data;
    tick();
    PENABLE = 1'b1;
  endtask

  int aw0, w0, b0, p0;
  int first_pr;
  logic seen_err, seen_bready;
  logic [31:0] seen_data;

  initial begin
    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_valids", {28'd0, AWVALID, WVALID, ARVALID, 1'b0}, 32'd0);
    chk("rst_readys", {30'd0, BREADY, RREADY}, 32'd0);
    chk("rst_awaddr", AWADDR, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    ARESETn = 1'b1;
    tick();

    // Write 0x1000 = 0xA5A5_0001, AW and W accepted together, OKAY
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; p0 = pr_cnt;
    apb_setup(1'b1, 32'h0000_1000, 32'hA5A5_0001);
    AWREADY = 1'b1; WREADY = 1'b1;
    chk("w1_t1_awvalid", 32'(AWVALID), 32'd1);
    chk("w1_t1_wvalid", 32'(WVALID), 32'd1);
    chk("w1_awaddr", AWADDR, 32'h0000_1000);
    chk("w1_wdata", WDATA, 32'hA5A5_0001);
    chk("w1_wstrb", 32'(WSTRB), 32'hF);
    tick();
    AWREADY = 1'b0; WREADY = 1'b0;
    chk("w1_t2_bready", 32'(BREADY), 32'd1);
    chk("w1_t2_valids_low", {30'd0, AWVALID, WVALID}, 32'd0);
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    chk("w1_t3_pready", 32'(PREADY), 32'd1);
    chk("w1_pslverr", 32'(PSLVERR), 32'd0);
    chk("w1_prdata", PRDATA, 32'd0);
    BVALID = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    chk("w1_pready_drop", 32'(PREADY), 32'd0);
    chk("w1_aw_beats", 32'(aw_hs - aw0), 32'd1);
    chk("w1_w_beats", 32'(w_hs - w0), 32'd1);
    chk("w1_b_beats", 32'(b_hs - b0), 32'd1);

    // Write with WREADY two cycles ahead of AWREADY; stray setup mid-transfer is ignored
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; p0 = pr_cnt;
    apb_setup(1'b1, 32'h0000_1008, 32'h0000_BEEF);
    WREADY = 1'b1;
    tick();
    chk("w2_wvalid_first", 32'(WVALID), 32'd0);
    chk("w2_awvalid_hold", 32'(AWVALID), 32'd1);
    WREADY = 1'b0;
    PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_3000;
    tick();
    chk("w2_awvalid_hold2", 32'(AWVALID), 32'd1);
    chk("w2_no_new_ar", 32'(ARVALID), 32'd0);
    chk("w2_awaddr_stable", AWADDR, 32'h0000_1008);
    chk("w2_bready_wait", 32'(BREADY), 32'd0);
    PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0000_1008;
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    chk("w2_awvalid_drop", 32'(AWVALID), 32'd0);
    chk("w2_bready", 32'(BREADY), 32'd1);
    BVALID = 1'b1;
    tick();
    chk("w2_pready", 32'(PREADY), 32'd1);
    chk("w2_bready_drop", 32'(BREADY), 32'd0);
    tick();
    chk("w2_pready_once", 32'(PREADY), 32'd0);
    BVALID = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    chk("w2_b_beats", 32'(b_hs - b0), 32'd1);
    chk("w2_pready_cnt", 32'(pr_cnt - p0), 32'd1);
    chk("w2_aw_beats", 32'(aw_hs - aw0), 32'd1);
    chk("w2_w_beats", 32'(w_hs - w0), 32'd1);

    // Read 0x2004, ARREADY after 3 cycles, SLVERR; APB drops PSEL mid-transfer
    p0 = pr_cnt;
    apb_setup(1'b0, 32'h0000_2004, 32'd0);
    chk("r1_arvalid", 32'(ARVALID), 32'd1);
    chk("r1_araddr", ARADDR, 32'h0000_2004);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (3) tick();
    chk("r1_arvalid_hold", 32'(ARVALID), 32'd1);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk("r1_arvalid_drop", 32'(ARVALID), 32'd0);
    chk("r1_rready", 32'(RREADY), 32'd1);
    RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b10;
    tick();
    RVALID = 1'b0;
    chk("r1_pready", 32'(PREADY), 32'd1);
    chk("r1_prdata", PRDATA, 32'h1234_5678);
    chk("r1_pslverr", 32'(PSLVERR), 32'd1);
    chk("r1_rready_drop", 32'(RREADY), 32'd0);
    tick();
    chk("r1_pready_cnt", 32'(pr_cnt - p0), 32'd1);

    // Reset during WR_RESP, then a clean read
    apb_setup(1'b1, 32'h0000_4000, 32'h1111_2222);
    AWREADY = 1'b1; WREADY = 1'b1;
    tick();
    AWREADY = 1'b0; WREADY = 1'b0;
    chk("rs_in_wr_resp", 32'(BREADY), 32'd1);
    #2 ARESETn = 1'b0;
    #1;
    chk("rs_bready", 32'(BREADY), 32'd0);
    chk("rs_prdata", PRDATA, 32'd0);
    chk("rs_pslverr", 32'(PSLVERR), 32'd0);
    chk("rs_awaddr", AWADDR, 32'd0);
    chk("rs_wdata", WDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    apb_setup(1'b0, 32'h0000_2008, 32'd0);
    ARREADY = 1'b1;
    chk("rs_rd_arvalid", 32'(ARVALID), 32'd1);
    tick();
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = 32'hCAFE_0042; RRESP = 2'b00;
    tick();
    RVALID = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    chk("rs_rd_pready", 32'(PREADY), 32'd1);
    chk("rs_rd_prdata", PRDATA, 32'hCAFE_0042);
    chk("rs_rd_pslverr", 32'(PSLVERR), 32'd0);
    tick();

    // Write whose B response never arrives
    first_pr = 0; seen_err = 1'b0; seen_data = '0; seen_bready = 1'b0;
    apb_setup(1'b1, 32'h0000_5000, 32'h0000_0005);
    AWREADY = 1'b1; WREADY = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      AWREADY = 1'b0; WREADY = 1'b0;
      if (PREADY && first_pr == 0) begin
        first_pr    = i;
        seen_err    = PSLVERR;
        seen_data   = PRDATA;
        seen_bready = BREADY;
      end
    end
`ifdef APB_AXI_BRIDGE_TIMEOUT_EN
    chk("to_pready_cycle", 32'(first_pr), 32'd9);
    chk("to_pslverr", 32'(seen_err), 32'd1);
    chk("to_prdata", seen_data, 32'hDEAD_BEEF);
    chk("to_bready", 32'(seen_bready), 32'd0);
`else
    chk("to_no_pready", 32'(first_pr), 32'd0);
    chk("to_bready_wait", 32'(BREADY), 32'd1);
`endif
    PSEL = 1'b0; PENABLE = 1'b0;
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
